pwconv_data_stager: RTL
=======================

# pwconv_data_stager

Parametrised ping-pong staging buffer between the feature-map fetch stage and the pointwise-convolution MAC array. It accepts one complete pixel position (all lanes × all channels) per handshake beat and holds it across two buffers. It presents the front buffer to the MAC array while sequencing an internal channel counter 0..CH-1. When the counter reaches CH-1 it swaps to the back buffer with no bubble, so the fetch stage can prefetch the next position while the current one is consumed.

## Interface
- CH, 32, channels per position; the counter wraps at CH-1; CH ≥ 2.
- DW, 8, bits per channel element.
- LANES, 4, parallel lanes (output pixels / kernels fed in parallel).
- POSW, 4, width of the position tag.
- CW, $clog2(CH), channel counter width (derived, not overridable).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_b  in  1  reset: synchronous and active-low.
- clr  in  1  synchronous flush; empties both buffers and zeroes the counter.
- in_valid  in  1  producer has a position available.
- in_ready  out  1  stager can accept a position this cycle.
- in_pos  in  POSW  position tag of the incoming data.
- in_data  in  LANES*CH*DW  lane-major data; lane 0 occupies the MSBs.
- adv  in  1  MAC array consumed the current channel; advance.
- out_valid  out  1  front buffer holds a valid position.
- out_cnt  out  CW  current channel index.
- out_last  out  1  out_valid && out_cnt==CH-1.
- out_pos  out  POSW  tag of the front buffer.
- out_data  out  LANES*CH*DW  front buffer contents; stable for the whole position.

## Operation
- State: two buffers {pos, data}, wr_ptr, rd_ptr, occ (0..2), cnt.
- in_ready = rst_b && !clr && occ<2. It depends only on registered occ, with no combinational path from adv. A full stager does not accept input in the same cycle as a final pop.
- Push occurs when in_valid && in_ready: buf[wr_ptr] ← {in_pos, in_data}; wr_ptr flips; occ+1.
- out_valid = occ!=0. out_pos/out_data = buf[rd_ptr], a combinational mux of registered storage.
- Pop occurs when out_valid && adv:
  - If cnt<CH-1: cnt+1.
  - If cnt==CH-1: cnt←0; rd_ptr flips; occ−1.
- adv while !out_valid is ignored; cnt holds 0.
- Simultaneous push and final pop: occ is unchanged, both pointers flip. With occ==1 this gives a back-to-back position with no bubble.
- clr has priority over push/pop. It sets occ←0, cnt←0, wr_ptr←rd_ptr←0. Buffer contents are retained but invisible because out_valid=0.
- Reset values: occ 0, both pointers 0, cnt 0, both buffers all-zero. Consequently out_valid 0, out_cnt 0, out_last 0, out_pos 0, out_data 0, and in_ready 0 while rst_b=0.
- A reset asserted mid-position discards both buffers and any partial channel count.

## Timing
- Fill latency: a push in cycle t with occ==0 gives out_valid=1, out_cnt=0 and the new data in cycle t+1.
- Throughput: one position per CH cycles with adv held high and the producer keeping occ ≥1.
- out_cnt advances on the clock edge after adv is sampled high; out_last is combinational from registered state.
- in_ready rises the cycle after the final pop that drops occ 2→1.
- out_data and out_pos change only on a final pop, clr, or reset.

## Structure
- pwconv_pkg holds the default constants (PW_CH=32, PW_DW=8, PW_LANES=4, PW_POSW=4) and a function for the flat lane/channel slice offset.
- Sub-module pwconv_pingpong_buf holds the two-entry storage with its write/read pointers and occupancy. The top level adds the channel counter, handshake, and clr.

## Test plan
- Reset then idle: after rst_b releases, in_ready=1, out_valid=0, out_data=0. Pulse adv ×5 → out_cnt stays 0.
- Single position: push pos=3, data=ramp. Next cycle out_valid=1, out_pos=3. Hold adv for 32 cycles → out_cnt 0..31, out_last only at 31, then out_valid=0.
- Back-to-back: push pos=1 and pos=2, then hold adv. out_pos switches 1→2 exactly after cnt 31→0 with no gap. in_ready=0 while occ=2 and returns one cycle after the first position drains.
- Stall: push; adv toggles 1,0,0,1. out_cnt holds during the 0 cycles, and out_data stays unchanged throughout.
- Full plus simultaneous pop/push: with occ=2, a final pop leaves in_ready=0 in that cycle. With occ=1, a final pop and a push in the same cycle keep occ=1, and the new pos appears on the next cycle.
- clr and reset mid-position: at out_cnt=17 with occ=2, assert clr → next cycle out_valid=0, out_cnt=0, in_ready=1. Repeat with rst_b=0 instead → identical result, plus out_data=0.

Source files
------------

// File: rtl/pwconv_pkg.sv
// Shared constants and layout helpers for the pointwise-conv data stager.
package pwconv_pkg;

  localparam int PW_CH    = 32;
  localparam int PW_DW    = 8;
  localparam int PW_LANES = 4;
  localparam int PW_POSW  = 4;

  // LSB of one lane/channel element in the flat bus; lane 0 and channel 0 sit at the MSBs.
  function automatic int unsigned pw_slice_lsb(input int unsigned lane, input int unsigned ch,
                                               input int unsigned lanes, input int unsigned chs,
                                               input int unsigned dw);
    return ((lanes - 1 - lane) * chs + (chs - 1 - ch)) * dw;
  endfunction

endpackage

// File: rtl/pwconv_data_stager_if.sv
// Fetch-side push handshake plus MAC-side channel-sequenced read port.
interface pwconv_data_stager_if
  import pwconv_pkg::*;
#(
  parameter int CH    = PW_CH,
  parameter int DW    = PW_DW,
  parameter int LANES = PW_LANES,
  parameter int POSW  = PW_POSW
);
  localparam int CW = $clog2(CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [POSW-1:0]          in_pos;
  logic [LANES*CH*DW-1:0]   in_data;
  logic                     adv;
  logic                     out_valid;
  logic [CW-1:0]            out_cnt;
  logic                     out_last;
  logic [POSW-1:0]          out_pos;
  logic [LANES*CH*DW-1:0]   out_data;

  modport master (
    output in_valid, in_pos, in_data, adv,
    input  in_ready, out_valid, out_cnt, out_last, out_pos, out_data
  );

  modport slave (
    input  in_valid, in_pos, in_data, adv,
    output in_ready, out_valid, out_cnt, out_last, out_pos, out_data
  );

endinterface

// File: rtl/pwconv_pingpong_buf.sv
// Two-entry ping-pong store with write/read pointers and occupancy count.
module pwconv_pingpong_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;

  // Contents survive clr; only reset scrubs them.
  always_ff @(posedge clk) begin
    if (!rst_b)    mem <= '0;
    else if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_b || clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pwconv_data_stager.sv
// Ping-pong staging of whole pixel positions for the MAC array, stepping channels 0..CH-1.
module pwconv_data_stager
  import pwconv_pkg::*;
#(
  parameter int CH    = PW_CH,
  parameter int DW    = PW_DW,
  parameter int LANES = PW_LANES,
  parameter int POSW  = PW_POSW
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   clr,
  pwconv_data_stager_if.slave    bus
);

  localparam int CW = $clog2(CH);
  localparam int W  = LANES * CH * DW;

  logic [1:0]        occ;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              adv_ok;
  logic              last_pop;
  logic [POSW+W-1:0] rd_entry;

  // Ready looks only at registered occupancy, so a full stager waits one cycle after a final pop.
  assign bus.in_ready = rst_b && !clr && (occ != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;

  assign bus.out_valid = (occ != 2'd0);
  assign adv_ok        = bus.out_valid && bus.adv;
  assign last_pop      = adv_ok && (cnt == CW'(CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_b || clr)  cnt <= '0;
    else if (last_pop)  cnt <= '0;
    else if (adv_ok)    cnt <= cnt + CW'(1);
  end

  pwconv_pingpong_buf #(.W(POSW + W)) u_buf (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (clr),
    .push  (push),
    .pop   (last_pop),
    .wdata ({bus.in_pos, bus.in_data}),
    .rdata (rd_entry),
    .occ   (occ)
  );

  assign bus.out_cnt  = cnt;
  assign bus.out_last = bus.out_valid && (cnt == CW'(CH - 1));
  assign bus.out_pos  = rd_entry[POSW+W-1:W];
  assign bus.out_data = rd_entry[W-1:0];

endmodule
